// File: rtl/id_skid_chain.sv
// Elastic pass-through: STAGES cascaded 2-entry skid stages carrying samples unchanged under valid/ready.
// Optional ID_SKID_CHAIN_STATS_EN adds occupancy and y transfer count outputs.
module id_skid_chain #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] x,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic signed [WIDTH-1:0] y,
  output logic                    y_valid,
  input  logic                    y_ready
`ifdef ID_SKID_CHAIN_STATS_EN
  ,
  output logic [$clog2(2*STAGES+1)-1:0] occupancy,
  output logic [31:0]                   xfer_count
`endif
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  // Index k is the input side of stage k; index k+1 is its output side.
  logic [STAGES:0]  c_valid;
  logic [STAGES:0]  c_ready;
  logic [WIDTH-1:0] c_data [STAGES+1];

  assign c_valid[0]      = x_valid;
  assign c_data[0]       = x;
  assign x_ready         = c_ready[0];
  assign y_valid         = c_valid[STAGES];
  assign y               = c_data[STAGES];
  assign c_ready[STAGES] = y_ready;

`ifdef ID_SKID_CHAIN_STATS_EN
  logic [1:0] fill [STAGES];
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, s_q;
    logic             rdy_q;
    logic             acc, take;

    assign acc  = c_valid[k] & rdy_q;
    assign take = c_valid[k+1] & c_ready[k+1];

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        EMPTY: if (acc) state_d = BUSY;
        BUSY: begin
          if (acc && !take)      state_d = FULL;
          else if (!acc && take) state_d = EMPTY;
        end
        FULL:    if (take) state_d = BUSY;
        default: state_d = EMPTY;
      endcase
    end

    // rdy_q is 0 in reset and comes up on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= EMPTY;
        rdy_q   <= 1'b0;
        m_q     <= '0;
        s_q     <= '0;
      end else begin
        state_q <= state_d;
        rdy_q   <= (state_d != FULL);
        unique case (state_q)
          EMPTY: if (acc) m_q <= c_data[k];
          BUSY: begin
            if (acc && take) m_q <= c_data[k];
            else if (acc)    s_q <= c_data[k];
          end
          FULL:    if (take) m_q <= s_q;
          default: ;
        endcase
      end
    end

    assign c_valid[k+1] = (state_q != EMPTY);
    assign c_data[k+1]  = m_q;
    assign c_ready[k]   = rdy_q;

`ifdef ID_SKID_CHAIN_STATS_EN
    assign fill[k] = (state_q == FULL) ? 2'd2 : (state_q == BUSY) ? 2'd1 : 2'd0;
`endif
  end

`ifdef ID_SKID_CHAIN_STATS_EN
  localparam int OCC_W = $clog2(2*STAGES+1);
  logic [OCC_W-1:0] occ_sum;
  logic [31:0]      xfer_cnt_q;

  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < STAGES; k++) occ_sum = occ_sum + OCC_W'(fill[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     xfer_cnt_q <= '0;
    else if (y_valid && y_ready) xfer_cnt_q <= xfer_cnt_q + 32'd1;
  end

  assign occupancy  = occ_sum;
  assign xfer_count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_id_skid_chain.sv
// Scoreboard bench for id_skid_chain: a STAGES=2 instance checked against a FIFO model,
// plus STAGES=1 and STAGES=8 instances for latency and capacity.
module tb_id_skid_chain;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] x, y;
  logic        x_valid, x_ready, y_valid, y_ready;

  logic [15:0] m_x, y1, y8;
  logic        m_valid, m_ready, xr1, xr8, yv1, yv8;

`ifdef ID_SKID_CHAIN_STATS_EN
  logic [2:0]  occ2;
  logic [1:0]  occ1;
  logic [4:0]  occ8;
  logic [31:0] xc2, xc1, xc8;
`endif

  id_skid_chain #(.WIDTH(16), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .x_ready(x_ready),
    .y(y), .y_valid(y_valid), .y_ready(y_ready)
`ifdef ID_SKID_CHAIN_STATS_EN
    , .occupancy(occ2), .xfer_count(xc2)
`endif
  );

  id_skid_chain #(.WIDTH(16), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .x(m_x), .x_valid(m_valid), .x_ready(xr1),
    .y(y1), .y_valid(yv1), .y_ready(m_ready)
`ifdef ID_SKID_CHAIN_STATS_EN
    , .occupancy(occ1), .xfer_count(xc1)
`endif
  );

  id_skid_chain #(.WIDTH(16), .STAGES(8)) dut8 (
    .clk(clk), .rst(rst), .x(m_x), .x_valid(m_valid), .x_ready(xr8),
    .y(y8), .y_valid(yv8), .y_ready(m_ready)
`ifdef ID_SKID_CHAIN_STATS_EN
    , .occupancy(occ8), .xfer_count(xc8)
`endif
  );

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lat_chk = -1;
  int   sink_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Consumer: 0 = stall, 1 = always ready, 2 = random.
  initial begin
    y_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (sink_mode)
        0:       y_ready = 1'b0;
        1:       y_ready = 1'b1;
        default: y_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: pops the model FIFO on every y transfer and checks stall stability.
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [15:0] prev_y;
    prev_stall = 1'b0;
    prev_y = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(y_valid), 32'd1);
          check("stall_data", 32'(y), 32'(prev_y));
        end
        if (y_valid && y_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 32'(y_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("data", 32'(y), 32'(e.d));
            if (lat_chk >= 0) check("latency", 32'(cyc - e.c), 32'(lat_chk));
          end
        end
        prev_stall = y_valid && !y_ready;
        prev_y = y;
      end
    end
  end

  task automatic send(input logic [15:0] v, input int max);
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      x = v;
      x_valid = 1'b1;
      #1;
      if (x_ready) begin
        exp_q.push_back(exp_t'{d: v, c: cyc});
        done = 1;
      end else if (++n >= max) begin
        check("send_timeout", 32'd0, 32'd1);
        x_valid = 1'b0;
        done = 1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() > 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vals [5];
    int lat1, lat8, c0, k1, k8, d1, d8;
    logic [15:0] yl1, yl8;

    rst = 1'b1;
    x = '0; x_valid = 1'b0;
    m_x = '0; m_valid = 1'b0; m_ready = 1'b1;
    #1;
    check("rst_x_ready", 32'(x_ready), 32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_y_valid8", 32'(yv8), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_x_ready", 32'(x_ready), 32'd0);
    @(posedge clk);
    #1;
    check("first_edge_x_ready", 32'(x_ready), 32'd1);
    check("first_edge_x_ready1", 32'(xr1), 32'd1);
    check("first_edge_x_ready8", 32'(xr8), 32'd1);

    // Full-rate stream: every sample accepted on its first cycle, latency 2.
    lat_chk = 2;
    for (int i = 1; i <= 10; i++) send(16'(i), 1);
    idle();
    wait_drain(20);
    lat_chk = -1;

    // Capacity 4 with the consumer stalled, then drain in order.
    sink_mode = 0;
    vals[0] = 16'h7FFF; vals[1] = 16'h8000; vals[2] = 16'hFFFF;
    vals[3] = 16'h0000; vals[4] = 16'h0005;
    for (int i = 0; i < 4; i++) send(vals[i], 1);
    @(negedge clk);
    x = vals[4];
    x_valid = 1'b1;
    #1;
    check("cap_ready_low", 32'(x_ready), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("cap_ready_held", 32'(x_ready), 32'd0);
    check("cap_y_head", 32'(y), 32'h7FFF);
    sink_mode = 1;
    send(vals[4], 10);
    idle();
    wait_drain(20);

    // Random traffic against the FIFO model.
    sink_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 1) == 1) send(16'($urandom), 200);
      else idle();
    end
    idle();
    sink_mode = 1;
    wait_drain(50);

    // Asynchronous reset between edges with samples in flight.
    sink_mode = 0;
    for (int i = 0; i < 3; i++) send(16'(16'hA000 + i), 5);
    idle();
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_y_valid", 32'(y_valid), 32'd0);
    check("async_x_ready", 32'(x_ready), 32'd0);
    check("async_y", 32'(y), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sink_mode = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_idle", 32'(y_valid), 32'd0);
    end
    send(16'h1234, 5);
    idle();
    wait_drain(20);

    // STAGES=1 and STAGES=8: latency at full rate.
    lat1 = -1; lat8 = -1; yl1 = '0; yl8 = '0;
    @(negedge clk);
    m_x = 16'h0055;
    m_valid = 1'b1;
    #1;
    check("lat_accept1", 32'(xr1), 32'd1);
    check("lat_accept8", 32'(xr8), 32'd1);
    c0 = cyc;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      m_valid = 1'b0;
      #1;
      if (yv1 && lat1 < 0) begin lat1 = cyc - c0; yl1 = y1; end
      if (yv8 && lat8 < 0) begin lat8 = cyc - c0; yl8 = y8; end
    end
    check("latency_s1", 32'(lat1), 32'd1);
    check("latency_s8", 32'(lat8), 32'd8);
    check("lat_data_s1", 32'(yl1), 32'h0055);
    check("lat_data_s8", 32'(yl8), 32'h0055);

    // Capacity 2 and 16; drain must return every sample once, in order.
    m_ready = 1'b0;
    k1 = 0; k8 = 0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      m_x = 16'(k8);
      m_valid = 1'b1;
      #1;
      if (xr1) k1++;
      if (xr8) k8++;
    end
    @(negedge clk);
    m_valid = 1'b0;
    #1;
    check("capacity_s1", 32'(k1), 32'd2);
    check("capacity_s8", 32'(k8), 32'd16);
    check("full_ready_s1", 32'(xr1), 32'd0);
    check("full_ready_s8", 32'(xr8), 32'd0);
    d1 = 0; d8 = 0;
    m_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      #1;
      if (yv1) begin check("order_s1", 32'(y1), 32'(d1)); d1++; end
      if (yv8) begin check("order_s8", 32'(y8), 32'(d8)); d8++; end
      @(negedge clk);
    end
    check("drained_s1", 32'(d1), 32'd2);
    check("drained_s8", 32'(d8), 32'd16);

`ifdef ID_SKID_CHAIN_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("stats_rst_occ", 32'(occ2), 32'd0);
    check("stats_rst_cnt", xc2, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sink_mode = 0;
    for (int i = 0; i < 4; i++) send(16'(i + 40), 3);
    idle();
    #1;
    check("stats_occ_full", 32'(occ2), 32'd4);
    sink_mode = 1;
    wait_drain(20);
    #1;
    check("stats_occ_empty", 32'(occ2), 32'd0);
    check("stats_cnt4", xc2, 32'd4);
    @(negedge clk);
    dut2.xfer_cnt_q = 32'hFFFF_FFFF;
    send(16'd9, 5);
    idle();
    wait_drain(20);
    #1;
    check("stats_cnt_wrap", xc2, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
